btn_press_classifier: RTL and testbench
=======================================

// Module: btn_press_classifier
// PURPOSE
//  Consumes the debounced, synchronised button level from the debouncer stage and
//  turns it into single-cycle events: press, short press (released before the
//  long-press threshold), long press, and optional auto-repeat while held.
//  Feeds the DE0 lab control logic (menu step, counter increment, mode toggle).
// PARAMETERS
//  LONG_CYCLES    25_000_000  consecutive high samples to qualify a long press (0.5 s @ 50 MHz), >= 2
//  REPEAT_CYCLES  5_000_000   period of repeat_pulse while in LONG (auto-repeat build only), >= 2
//  CNT_W          $clog2(max(LONG_CYCLES,REPEAT_CYCLES))+1  internal counter width
// PORTS
//  clk           in   1  system clock; all logic on posedge
//  rst           in   1  asynchronous, active-high reset
//  in            in   1  debounced button level (already synchronous to clk)
//  press_pulse   out  1  1-cycle pulse: press accepted
//  short_pulse   out  1  1-cycle pulse: released before LONG_CYCLES samples
//  long_pulse    out  1  1-cycle pulse: LONG_CYCLES-th consecutive high sample
//  repeat_pulse  out  1  1-cycle pulse every REPEAT_CYCLES while in LONG
//  held          out  1  level: high while in LONG
// BEHAVIOUR
//  - All outputs registered. rst=1: state IDLE, counter 0, every output 0, immediately.
//  - Latency: an input sample at posedge k drives outputs visible after posedge k.
//  - FSM states IDLE, PRESS, LONG:
//    IDLE : in=1 -> PRESS, cnt<=1, press_pulse=1. in=0 -> stay.
//    PRESS: in=0 -> IDLE, short_pulse=1.
//           in=1 & cnt==LONG_CYCLES-1 -> LONG, cnt<=0, long_pulse=1, held=1.
//           in=1 otherwise -> cnt<=cnt+1.
//    LONG : in=0 -> IDLE, held=0, no pulse on release.
//           in=1 -> held stays 1; auto-repeat counting (see CONFIGURATION).
//  - Counting: press sampled at edge k -> long_pulse after edge k+LONG_CYCLES-1
//    (LONG_CYCLES high samples including the first). LONG_CYCLES-1 high samples
//    then a low sample -> short_pulse, never long_pulse.
//  - Threshold edge with in=0: in not high at that sample -> short_pulse.
//  - At most one of press/short/long/repeat pulses high in any cycle.
//  - Counter never wraps: cleared on every state transition, bounded by compares.
//  - in high when rst deasserts: treated as fresh press (press_pulse next edge).
//  - Reset mid-operation: pending events discarded, no pulse emitted.
// CONFIGURATION
//  Macro BTN_AUTOREPEAT_EN:
//  - Defined: in LONG with in=1, cnt increments; cnt==REPEAT_CYCLES-1 ->
//    repeat_pulse=1, cnt<=0. First repeat REPEAT_CYCLES samples after long_pulse.
//  - Undefined: repeat_pulse tied 0, no repeat counter logic; LONG only holds held.
// TESTING  (LONG_CYCLES=8, REPEAT_CYCLES=4)
//  1 rst=1 then 0, in=0 20 cycles -> all outputs 0 throughout.
//  2 in=1 for 3 samples then 0 -> press_pulse 1 cycle after 1st edge; short_pulse
//    1 cycle after 4th edge; long_pulse/held stay 0.
//  3 in=1 for exactly 7 samples then 0 -> short_pulse only; in=1 for 8 samples ->
//    long_pulse after 8th edge, held=1 until first low sample, no short_pulse.
//  4 BTN_AUTOREPEAT_EN, in=1 for 20 samples -> long_pulse at 8th, repeat_pulse at
//    12th, 16th, 20th edges; build without macro -> repeat_pulse always 0.
//  5 rst pulsed while held=1 and in=1 -> outputs 0 at once; after release
//    press_pulse on next edge, long_pulse 7 edges later.
//  6 in toggling every cycle (1,0,1,0..) -> alternating press/short pulses, never overlap.

Source files
------------

// File: rtl/btn_press_classifier.sv
// Turns a debounced button level into press / short / long / auto-repeat pulses plus a held level.
// Optional auto-repeat in LONG is enabled by defining BTN_AUTOREPEAT_EN.
module btn_press_classifier #(
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = $clog2((LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  // state | meaning
  // IDLE  | button released, waiting for a high sample
  // PRESS | held, counting towards the long-press threshold
  // LONG  | long press qualified, held asserted until release
  typedef enum logic [1:0] {IDLE, PRESS, LONG} state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             press_n, short_n, long_n, held_n;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic repeat_n;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      press_pulse <= 1'b0;
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
      held        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      press_pulse <= press_n;
      short_pulse <= short_n;
      long_pulse  <= long_n;
      held        <= held_n;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) repeat_pulse <= 1'b0;
    else     repeat_pulse <= repeat_n;
  end
`else
  assign repeat_pulse = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    press_n = 1'b0;
    short_n = 1'b0;
    long_n  = 1'b0;
    held_n  = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    repeat_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (in) begin
          state_n = PRESS;
          cnt_n   = CNT_W'(1);
          press_n = 1'b1;
        end
      end
      PRESS: begin
        if (!in) begin
          state_n = IDLE;
          cnt_n   = '0;
          short_n = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n = LONG;
          cnt_n   = '0;
          long_n  = 1'b1;
          held_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      LONG: begin
        if (!in) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          held_n = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          // Counter restarts on each repeat so the period is exactly REPEAT_CYCLES samples.
          if (cnt == REP_LAST) begin
            cnt_n    = '0;
            repeat_n = 1'b1;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
`endif
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Scoreboard bench for btn_press_classifier (LONG_CYCLES=8, REPEAT_CYCLES=4).
// Repeat expectations follow BTN_AUTOREPEAT_EN when the bench is built with it.
module tb_btn_press_classifier;

  localparam int LONG = 8;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_s = 1'b0;
  logic press_pulse, short_pulse, long_pulse, repeat_pulse, held;

  btn_press_classifier #(.LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)) dut (
    .clk(clk), .rst(rst), .in(in_s),
    .press_pulse(press_pulse), .short_pulse(short_pulse), .long_pulse(long_pulse),
    .repeat_pulse(repeat_pulse), .held(held)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n = edge_n + 1;

  // p = {repeat, long, short, press}
  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic       h;
  } ev_t;

  ev_t sb[$];
  int  n_vec = 0;
  int  n_bad = 0;
  logic held_prev = 1'b0;

  task automatic push(input int c, input logic [3:0] p, input logic h);
    ev_t e;
    e.cyc = c; e.p = p; e.h = h;
    sb.push_back(e);
  endtask

  // Monitor: fires whenever a pulse is present or held changes level.
  always @(negedge clk) begin
    logic [3:0] obs;
    ev_t e;
    obs = {repeat_pulse, long_pulse, short_pulse, press_pulse};
    while (sb.size() > 0 && sb[0].cyc < edge_n) begin
      e = sb.pop_front();
      n_vec++; n_bad++;
      $display("FAIL missed_event: expected p=%b h=%b at edge %0d, nothing seen", e.p, e.h, e.cyc);
    end
    if (obs != 4'b0 || held != held_prev) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got p=%b h=%b at edge %0d, queue empty", obs, held, edge_n);
      end else begin
        e = sb.pop_front();
        if (e.cyc != edge_n || e.p != obs || e.h != held) begin
          n_bad++;
          $display("FAIL event: got p=%b h=%b at edge %0d, expected p=%b h=%b at edge %0d",
                   obs, held, edge_n, e.p, e.h, e.cyc);
        end
      end
    end
    held_prev = held;
  end

  task automatic drive(input logic v, output int k);
    @(negedge clk);
    in_s = v;
    k = edge_n + 1;
  endtask

  task automatic idle(input int n);
    int k;
    for (int i = 0; i < n; i++) drive(1'b0, k);
  endtask

  task automatic check_zero(input string name);
    logic [4:0] o;
    o = {repeat_pulse, long_pulse, short_pulse, press_pulse, held};
    n_vec++;
    if (o != 5'b0) begin
      n_bad++;
      $display("FAIL %s: outputs=%b, expected 00000", name, o);
    end
  endtask

  // n high samples then one low sample.
  task automatic press_hold(input int n);
    int k0, k;
    drive(1'b1, k0);
    push(k0, 4'b0001, 1'b0);
    if (n >= LONG) begin
      push(k0 + LONG - 1, 4'b0100, 1'b1);
`ifdef BTN_AUTOREPEAT_EN
      for (int t = k0 + LONG - 1 + REP; t <= k0 + n - 1; t += REP) push(t, 4'b1000, 1'b1);
`endif
    end
    for (int i = 1; i < n; i++) drive(1'b1, k);
    drive(1'b0, k);
    if (n >= LONG) push(k, 4'b0000, 1'b0);
    else           push(k, 4'b0010, 1'b0);
  endtask

  initial begin
    int k0, kp, k;
    // 1: reset state and quiet idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check_zero("reset_state");
    end
    @(negedge clk); #1 rst = 1'b0;
    idle(20);

    // 2: short press of 3 samples
    press_hold(3);
    idle(3);

    // 3: threshold boundary, 7 samples -> short, 8 samples -> long
    press_hold(7);
    idle(3);
    press_hold(8);
    idle(3);

    // 4: long hold with auto-repeat window
    press_hold(20);
    idle(3);

    // 5: reset while held and in high, then fresh press after reset release
    drive(1'b1, k0);
    push(k0, 4'b0001, 1'b0);
    push(k0 + LONG - 1, 4'b0100, 1'b1);
    for (int i = 1; i < 10; i++) drive(1'b1, k);
    @(negedge clk);
    push(edge_n + 1, 4'b0000, 1'b0);
    #1 rst = 1'b1;
    #1 check_zero("reset_async");
    @(negedge clk);
    #1 check_zero("reset_held");
    rst = 1'b0;
    kp = edge_n + 1;
    push(kp, 4'b0001, 1'b0);
    push(kp + LONG - 1, 4'b0100, 1'b1);
    for (int i = 0; i < 8; i++) drive(1'b1, k);
    drive(1'b0, k);
    push(k, 4'b0000, 1'b0);
    idle(3);

    // 6: toggling input, alternating press/short
    for (int i = 0; i < 6; i++) press_hold(1);
    idle(5);

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d events left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
